// File: rtl/nt_node_misr_compactor.sv
// Response compactor for an Nt-node subcircuit under test: folds up to N_OBS node
// samples per valid cycle into a Galois MISR over a fixed window, then checks it against golden.
module nt_node_misr_compactor #(
    parameter int             SIG_W  = 16,
    parameter int             N_OBS  = 1,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED = SIG_W'(16'hFFFF),
    parameter int             WINDOW = 8
) (
    input  logic                           I1470,
    input  logic                           I1477,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           obs_valid,
    input  logic [N_OBS-1:0]               obs,
    input  logic [SIG_W-1:0]               golden,
    output logic                           busy,
    output logic                           done,
    output logic                           mismatch,
    output logic [SIG_W-1:0]               sig,
    output logic [$clog2(WINDOW+1)-1:0]    sample_cnt
);

    localparam int CNT_W = $clog2(WINDOW + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEED_ST,
        RUN,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    logic [SIG_W-1:0] obs_ext;
    logic [SIG_W-1:0] sig_next;
    logic [CNT_W-1:0] cnt_next;
    logic             last_sample;

    // Shift-left with conditional POLY feedback, then inject the zero-extended sample.
    always_comb begin
        obs_ext              = '0;
        obs_ext[N_OBS-1:0]   = obs;
        sig_next             = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ obs_ext;
        cnt_next             = sample_cnt + CNT_W'(1);
        last_sample          = (cnt_next == CNT_W'(WINDOW));
    end

    always_ff @(posedge I1470) begin
        if (I1477) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mismatch   <= 1'b0;
            sig        <= '0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= SEED_ST;
                        busy  <= 1'b1;
                    end
                end
                SEED_ST: begin
                    sig        <= SEED;
                    sample_cnt <= '0;
                    done       <= 1'b0;
                    mismatch   <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over a coincident sample so the partial signature is left untouched.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (obs_valid) begin
                        sig        <= sig_next;
                        sample_cnt <= cnt_next;
                        if (last_sample) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    mismatch <= (sig != golden);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    // Dropping done on restart keeps it a one-cycle pulse when start is held high.
                    if (start && !abort) begin
                        state <= SEED_ST;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
